// File: rtl/adder_accumulator.sv
// Multi-operand accumulation stage feeding an external combinational adder.
// Operands stream in over valid/ready; the final sum, sticky overflow, zero and beat count leave over valid/ready.
module adder_accumulator #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_sub,
  input  logic                 in_last,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     add_i_1,
  output logic [WIDTH-1:0]     add_i_2,
  output logic                 add_invert_i_2,
  output logic                 add_enable,
  input  logic [WIDTH-1:0]     add_o,
  input  logic                 add_overflow_flag,
  output logic [WIDTH-1:0]     out_sum,
  output logic                 out_overflow,
  output logic                 out_zero,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready does not depend on in_valid; out_valid does not depend on out_ready.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     acc;
  logic                 sticky;
  logic [CNT_WIDTH-1:0] count;
  logic                 accept;
  logic                 sticky_next;
  logic [CNT_WIDTH-1:0] count_next;

  assign dbg_state = state;
  assign in_ready  = !rst && (state != DONE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

  assign add_i_1        = (state == IDLE) ? '0 : acc;
  assign add_i_2        = accept ? in_data : '0;
  assign add_invert_i_2 = in_sub && accept;
  assign add_enable     = accept;

  always_comb begin
    state_next  = state;
    sticky_next = sticky | add_overflow_flag;
    count_next  = (count == CNT_MAX) ? count : count + CNT_ONE;
    // A new group never inherits flag or count from the previous one.
    if (state == IDLE) begin
      sticky_next = add_overflow_flag;
      count_next  = CNT_ONE;
    end
    case (state)
      IDLE: begin
        if (accept) state_next = in_last ? DONE : ACCUM;
      end
      ACCUM: begin
        if (accept && in_last) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      sticky       <= 1'b0;
      count        <= '0;
      out_sum      <= '0;
      out_overflow <= 1'b0;
      out_zero     <= 1'b0;
      out_count    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        acc    <= add_o;
        sticky <= sticky_next;
        count  <= count_next;
        if (in_last) begin
          out_sum      <= add_o;
          out_overflow <= sticky_next;
          out_zero     <= (add_o == '0);
          out_count    <= count_next;
        end
      end else if (state == DONE && out_ready) begin
        // Result outputs keep their value after release; only the working state clears.
        acc    <= '0;
        sticky <= 1'b0;
        count  <= '0;
      end
    end
  end

endmodule
